// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone single-transfer initiator.
// Provides the FSM state enum, default bus widths and the timeout counter width.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Counter must hold 0..timeout-1; never narrower than one bit.
  function automatic int cnt_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_initiator.sv
// Classic Wishbone single-transfer master driven by a valid/ready command
// port. Ports: wb_clk_i/wb_rst_i (sync, active-high), cmd_* command in,
// rsp_* one-cycle response out, busy, wbm_* Wishbone master signals.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADR_W          = WB_ADR_W,
  parameter int DAT_W          = WB_DAT_W
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_dat,
  input  logic [DAT_W/8-1:0] cmd_sel,
  output logic               rsp_valid,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               busy,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i
);

  localparam int SEL_W = DAT_W / 8;
  localparam int CW    = cnt_w(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TERM =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            cnt       <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // Ack is checked first so it wins over a same-edge timeout.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (TO_EN && cnt == TERM) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (TO_EN) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
        end
      endcase
    end
  end

  logic unused_sel_w;
  assign unused_sel_w = (SEL_W == 0);

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator with a small wait-state slave model.
// Table-driven single transfers plus reset, back-to-back and stray-ack cases.
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack;

  int          errors = 0;
  int          checks = 0;

  // slave model
  bit          slv_on;
  int          slv_ws;
  int          ws_cnt;
  logic [31:0] slv_rdata;
  bit          slv_adr_mode;
  bit          stray_ack;

  always #5 clk = ~clk;

  assign ack = (slv_on && stb && ws_cnt == slv_ws) || stray_ack;
  assign rdat = !ack ? 32'hDEAD_BEEF :
                slv_adr_mode ? (adr ^ 32'h5A5A_0000) : slv_rdata;

  always @(posedge clk) begin
    if (stb && !ack) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  wb_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_adr_o(adr),
    .wbm_dat_o(wdat),
    .wbm_sel_o(sel),
    .wbm_dat_i(rdat),
    .wbm_ack_i(ack)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ws;
    bit          on;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_stb;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v, input int idx);
    int  stb_cnt;
    bit  bad;
    bit  seen;
    logic [31:0] held;
    stb_cnt = 0;
    bad = 0;
    seen = 0;
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), {31'd0, cmd_ready}, 32'd1);
    slv_on = v.on;
    slv_ws = v.ws;
    slv_rdata = v.rdata;
    cmd_valid = 1'b1;
    cmd_we = v.we;
    cmd_adr = v.adr;
    cmd_dat = v.dat;
    cmd_sel = v.sel;
    @(negedge clk);
    // change fields after accept; they must be ignored
    cmd_valid = 1'b0;
    cmd_we = ~v.we;
    cmd_adr = ~v.adr;
    cmd_dat = ~v.dat;
    cmd_sel = ~v.sel;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      if (stb) begin
        stb_cnt++;
        if (!cyc || we !== v.we || adr !== v.adr ||
            wdat !== v.dat || sel !== v.sel || cmd_ready || !busy)
          bad = 1;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d rsp_seen", idx), {31'd0, seen}, 32'd1);
    chk($sformatf("v%0d fields", idx), {31'd0, bad}, 32'd0);
    chk($sformatf("v%0d stb_cycles", idx), stb_cnt, v.exp_stb);
    chk($sformatf("v%0d rsp_err", idx), {31'd0, rsp_err},
        {31'd0, v.exp_err});
    chk($sformatf("v%0d rsp_dat", idx), rsp_dat, v.exp_dat);
    chk($sformatf("v%0d cyc_stb_resp", idx), {30'd0, cyc, stb}, 32'd0);
    chk($sformatf("v%0d ready_resp", idx), {31'd0, cmd_ready}, 32'd0);
    held = rsp_dat;
    @(negedge clk);
    chk($sformatf("v%0d one_pulse", idx), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d ready_back", idx), {30'd0, cmd_ready, busy},
        32'd2);
    chk($sformatf("v%0d dat_hold", idx), rsp_dat, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nrsp;
    int rsp_cyc[$];
    logic [31:0] rsp_d[$];
    int cyc_no;

    vt[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 1'b1,
              32'h1111_2222, 1'b0, 32'h0, 1};
    vt[1] = '{1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 1'b1,
              32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 4};
    vt[2] = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 1'b0,
              32'h0, 1'b1, 32'h0, 8};
    vt[3] = '{1'b0, 32'h3000_0024, 32'h0, 4'hF, 7, 1'b1,
              32'h0000_0001, 1'b0, 32'h0000_0001, 8};
    vt[4] = '{1'b1, 32'h3000_0100, 32'h0BAD_BEEF, 4'h3, 2, 1'b1,
              32'hFFFF_FFFF, 1'b0, 32'h0, 3};
    vt[5] = '{1'b0, 32'h3000_0200, 32'h0, 4'h1, 0, 1'b1,
              32'h8765_4321, 1'b0, 32'h8765_4321, 1};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_adr = '0;
    cmd_dat = '0;
    cmd_sel = '0;
    slv_on = 1'b1;
    slv_ws = 0;
    slv_rdata = '0;
    slv_adr_mode = 1'b0;
    stray_ack = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst outs", {26'd0, rsp_valid, rsp_err, busy, cyc, stb, we},
        32'd0);
    chk("rst adr_dat", adr | wdat | rsp_dat | {28'd0, sel}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // reset during BUS
    @(negedge clk);
    slv_on = 1'b0;
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h3000_0300;
    cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid stb_up", {30'd0, cyc, stb}, 32'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid cyc_stb", {30'd0, cyc, stb}, 32'd0);
    chk("mid ready", {30'd0, cmd_ready, busy}, 32'd2);
    nrsp = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) nrsp++;
      @(negedge clk);
    end
    chk("mid no_rsp", nrsp, 0);
    run_vec(vt[1], 6);

    // back-to-back reads with cmd_valid held
    slv_on = 1'b1;
    slv_ws = 0;
    slv_adr_mode = 1'b1;
    k = 0;
    cyc_no = 0;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      stray_ack = 1'b0;
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc_no);
        rsp_d.push_back(rsp_dat);
        stray_ack = 1'b1;
      end
      if (cmd_ready) begin
        if (k < 4) begin
          cmd_valid = 1'b1;
          cmd_we = 1'b0;
          cmd_adr = 32'(k * 4);
          k++;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      cyc_no++;
      @(negedge clk);
    end
    stray_ack = 1'b0;
    cmd_valid = 1'b0;
    chk("b2b count", rsp_cyc.size(), 4);
    if (rsp_cyc.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("b2b dat%0d", j), rsp_d[j],
            32'(j * 4) ^ 32'h5A5A_0000);
        if (j > 0)
          chk($sformatf("b2b gap%0d", j), rsp_cyc[j] - rsp_cyc[j-1], 3);
      end
    end

    // stray ack in IDLE
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    chk("stray idle", {28'd0, rsp_valid, busy, cyc, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("stray after", {29'd0, rsp_valid, busy, cmd_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Classic Wishbone single-transfer bus master. It issues one read or write at a time into the user project's Wishbone slave port (wbs_* at the wrapper boundary).
- Driven by a simple valid/ready command interface, typically fed from logic-analyzer probes or a test sequencer in the user area.
- Returns read data and completion status on a one-cycle response strobe.
- A no-acknowledge timeout guarantees the bus is never hung.

Parameters:
- TIMEOUT_CYCLES, 255: cycles with stb high and no ack before the transfer is aborted. 0 disables the timeout.
- ADR_W, 32: address width.
- DAT_W, 32: data width. The sel width is DAT_W/8.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  ADR_W  byte address
- cmd_dat  in  DAT_W  write data
- cmd_sel  in  DAT_W/8  byte select
- rsp_valid  out  1  one-cycle completion pulse
- rsp_dat  out  DAT_W  read data (0 for writes and errors)
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  transfer in flight
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  ADR_W  Wishbone address
- wbm_dat_o  out  DAT_W  Wishbone write data
- wbm_sel_o  out  DAT_W/8  Wishbone byte select
- wbm_dat_i  in  DAT_W  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Clock and reset: single clock wb_clk_i; reset wb_rst_i is synchronous and active-high.
- All outputs are registered.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_dat=0, rsp_err=0, busy=0, cyc/stb/we=0, adr/dat/sel=0, state=IDLE, timeout counter=0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid&&cmd_ready: latch we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, busy=1, cmd_ready=0, counter=0, then go to BUS.
  - Fields are sampled only at the accept edge; later changes are ignored.
- BUS:
  - cyc, stb and the latched fields are held stable.
  - ack_i sampled high:
    - cyc/stb/we drop at that edge.
    - rsp_dat=wbm_dat_i for reads, 0 for writes; rsp_err=0; rsp_valid=1.
    - Go to RESP.
  - No ack, TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1:
    - cyc/stb drop; rsp_dat=0; rsp_err=1; rsp_valid=1.
    - Go to RESP.
  - Otherwise the counter increments.
  - Ack and timeout on the same edge: ack wins, normal completion.
- RESP:
  - rsp_valid is high for exactly this one cycle; cmd_ready=0.
  - At the next edge: rsp_valid=0, busy=0, cmd_ready=1, go to IDLE.
  - rsp_dat/rsp_err hold their values until the next completion.
- Latency: command accepted at edge N; with a combinational-ack slave, ack is sampled at N+1 and rsp_valid is high N+1..N+2.
  - cmd_ready returns at N+2.
  - Minimum of 3 cycles per transfer.
  - A cmd_valid held high issues back-to-back transfers at that rate.
- ack_i in IDLE or RESP: ignored, no state change.
- wbm_dat_i: ignored outside BUS and for writes.
- Reset mid-transfer: the first edge with reset high forces the reset values. cyc/stb drop immediately; no rsp_valid is produced for the aborted transfer.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1; it never wraps because BUS exits at the terminal count.
- Only single classic cycles are issued: no bursts, no cti/bte, no err_i/rty_i.

Decomposition:
- Package wb_pkg:
  - state enum {IDLE, BUS, RESP};
  - localparams WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4;
  - function for the timeout counter width.
- Single module, no sub-module. The timeout counter is simple enough to stay inline.

Test Plan:
- Write: cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF; slave acks the cycle after stb. Required: wbm_* match the command while stb=1; rsp_valid pulses once; rsp_err=0; rsp_dat=0; cmd_ready returns 1 cycle later.
- Read with 3 wait states: slave returns 0xCAFE_F00D. Required: stb high for 4 cycles; rsp_dat=0xCAFE_F00D; rsp_err=0.
- Timeout (TIMEOUT_CYCLES=8): slave never acks. Required: stb high for exactly 8 cycles, then drops; rsp_valid=1, rsp_err=1, rsp_dat=0.
- Ack on the terminal timeout cycle: TIMEOUT_CYCLES=8, ack in the 8th stb cycle with data 0x1. Required: rsp_err=0, rsp_dat=0x1.
- Reset mid-transfer: wb_rst_i high for 1 cycle during BUS. Required: cyc/stb low on that edge; no rsp_valid; cmd_ready=1; a following read completes normally.
- Back-to-back: cmd_valid held for 4 reads at addresses 0,4,8,C. Required: 4 rsp_valid pulses spaced 3 cycles apart; stray ack in IDLE has no effect.
